vga_draw_arbiter: RTL
=====================

// Module: vga_draw_arbiter
// PURPOSE
// - Downstream stage of the UI draw units (clear, shape, and text drawers); sits between them and vga_adapter.
// - Arbitrates NUM_CLIENTS pixel streams (x, y, color, writeEn) with a round-robin policy.
// - Grants exactly one client at a time and forwards that client's pixels, registered, to the single VGA write port.
// - Holds a grant until the client finishes, withdraws its request, or stalls past a watchdog limit.
// PARAMETERS
// - NUM_CLIENTS      4         number of draw units; legal range 2..8
// - TIMEOUT_CYCLES   1048576   granted-client idle cycles (no wr_in, no done) before forced release
// - TO_W             21        width of timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES
// PORTS
// - clk         in   1              system clock (50 MHz)
// - reset_n     in   1              asynchronous, active-low reset
// - req         in   NUM_CLIENTS    client i requests the VGA port; level, held while drawing
// - done        in   NUM_CLIENTS    client i finished its drawing; a one-cycle pulse is sufficient
// - wr_in       in   NUM_CLIENTS    client i pixel write strobe
// - x_in        in   8*NUM_CLIENTS  client i x at bits [8i+7:8i]
// - y_in        in   7*NUM_CLIENTS  client i y at bits [7i+6:7i]
// - color_in    in   3*NUM_CLIENTS  client i color at bits [3i+2:3i]
// - grant       out  NUM_CLIENTS    one-hot grant, registered; all-zero when no client is granted
// - vga_x       out  8              pixel x to vga_adapter
// - vga_y       out  7              pixel y to vga_adapter
// - vga_color   out  3              pixel color to vga_adapter
// - vga_plot    out  1              pixel write enable to vga_adapter
// - busy        out  1              1 in the GRANT and RELEASE states
// BEHAVIOUR
// - Reset (async, reset_n=0) drives: state=IDLE, grant=0, vga_x=0, vga_y=0, vga_color=0, vga_plot=0, busy=0.
//   Reset also sets the round-robin pointer to 0 and clears the timeout counter. Reset mid-grant aborts immediately.
// - State machine (3 states):
//   - IDLE: if req!=0, pick the first requester at or after ptr, wrapping modulo NUM_CLIENTS.
//     grant goes one-hot on the next edge; go to GRANT.
//   - GRANT: any of the following moves the FSM to RELEASE on the next edge:
//     done[g]=1; or req[g]=0; or timeout counter reaches TIMEOUT_CYCLES-1.
//   - RELEASE: one cycle; grant=0, vga_plot=0; ptr<=(g+1) mod NUM_CLIENTS; then IDLE.
// - Pixel path, GRANT only: vga_plot<=wr_in[g]; on wr_in[g], vga_x/y/color<=client g fields.
//   - Latency is exactly 1 cycle from wr_in to vga_plot.
//   - vga_x/y/color hold their last value when vga_plot=0.
// - wr_in from non-granted clients is dropped silently; no buffering, no back-pressure.
// - A wr_in[g] in the same cycle as done[g] or req[g] falling is still forwarded (last pixel kept).
// - Timeout counter clears on grant entry and on every wr_in[g]. It saturates and does not wrap.
// - Minimum request-to-first-plot: req rises in IDLE at T, grant at T+1, first plot at T+2 if wr_in[g] is high at T+1.
// - A client re-requesting immediately after its release is served only after the other pending requesters.
// - Fairness: with all clients requesting, each client gets one grant per NUM_CLIENTS grants.
// CONFIGURATION
// - DRAW_ARB_CLIP_EN defined:
//   - A granted pixel with x>=160 or y>=120 sets vga_plot=0 for that cycle.
//   - vga_x/y/color are not updated for a clipped pixel.
//   - A clipped pixel still clears the timeout counter.
// - DRAW_ARB_CLIP_EN undefined: all granted pixels are forwarded unmodified; vga_adapter handles range.
// TESTING
// - Reset: hold reset_n=0 with req=4'b1111 and wr_in=4'b1111.
//   -> grant=0, vga_plot=0, busy=0, and all outputs are 0 throughout.
// - Single client: req[1]=1, then client 1 writes (72,55,3'b111) for 256 cycles, then done[1].
//   -> grant=4'b0010 one cycle after req; 256 plots, each 1 cycle after its wr_in.
//   -> RELEASE cycle, then grant=0.
// - Round-robin: req=4'b1111 held, each client pulses done after 4 writes.
//   -> grant order 0,1,2,3,0; exactly one RELEASE cycle with vga_plot=0 between grants.
// - Foreign writes: client 2 granted, client 0 drives wr_in=1 with (10,10).
//   -> vga_x/vga_y never show (10,10); only client 2 pixels appear.
// - Watchdog: client 3 granted, then no wr_in and no done for TIMEOUT_CYCLES cycles.
//   -> forced RELEASE; with req=4'b1001 pending, grant moves to client 0.
// - Clip (DRAW_ARB_CLIP_EN): granted writes at (159,119) and (160,50).
//   -> first pixel plotted; second gives vga_plot=0 and vga_x stays 159.

Source files
------------

// File: rtl/vga_draw_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vga_draw_arbiter
// Purpose  : Round-robin arbiter between the UI draw units (clear, shape,
//            text) and the single vga_adapter write port. One client owns
//            the port at a time. Its pixels are forwarded with one cycle of
//            latency. The grant ends on done, on a dropped request, or when
//            a watchdog expires.
// Ports    : clk, reset_n (async, active-low)
//            req/done/wr_in [NUM_CLIENTS]    per-client handshake
//            x_in/y_in/color_in              packed per-client pixel fields
//            grant [NUM_CLIENTS]             registered one-hot grant
//            vga_x/vga_y/vga_color/vga_plot  registered pixel write port
//            busy                            high while a grant is active or
//                                            being released
// Options  : DRAW_ARB_CLIP_EN - suppresses granted pixels outside 160x120
//            and leaves the VGA fields unchanged for them.
// Revision : 1.0 - initial release
// ============================================================================
module vga_draw_arbiter #(
    parameter int NUM_CLIENTS    = 4,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int TO_W           = 21
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_CLIENTS-1:0]   req,
    input  logic [NUM_CLIENTS-1:0]   done,
    input  logic [NUM_CLIENTS-1:0]   wr_in,
    input  logic [8*NUM_CLIENTS-1:0] x_in,
    input  logic [7*NUM_CLIENTS-1:0] y_in,
    input  logic [3*NUM_CLIENTS-1:0] color_in,
    output logic [NUM_CLIENTS-1:0]   grant,
    output logic [7:0]               vga_x,
    output logic [6:0]               vga_y,
    output logic [2:0]               vga_color,
    output logic                     vga_plot,
    output logic                     busy
);

    localparam int IDX_W = $clog2(NUM_CLIENTS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_gidx;
    logic [NUM_CLIENTS-1:0] r_grant;
    logic [TO_W-1:0]    r_to_cnt;
    logic [7:0]         r_x;
    logic [6:0]         r_y;
    logic [2:0]         r_color;
    logic               r_plot;

    logic [IDX_W-1:0]   w_pick;
    logic               w_found;
    logic               w_g_req;
    logic               w_g_done;
    logic               w_g_wr;
    logic [7:0]         w_g_x;
    logic [6:0]         w_g_y;
    logic [2:0]         w_g_color;
    logic               w_clip;
    logic               w_timeout;
    logic               w_release;
    logic               w_fwd;

    // Search starts at the round-robin pointer and wraps, so the client just
    // released (pointer sits one past it) is visited last.
    always_comb begin
        w_pick  = '0;
        w_found = 1'b0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            if (!w_found && req[(int'(r_ptr) + k) % NUM_CLIENTS]) begin
                w_found = 1'b1;
                w_pick  = IDX_W'((int'(r_ptr) + k) % NUM_CLIENTS);
            end
        end
    end

    assign w_g_req   = req[r_gidx];
    assign w_g_done  = done[r_gidx];
    assign w_g_wr    = wr_in[r_gidx];
    assign w_g_x     = x_in[int'(r_gidx)*8 +: 8];
    assign w_g_y     = y_in[int'(r_gidx)*7 +: 7];
    assign w_g_color = color_in[int'(r_gidx)*3 +: 3];

`ifdef DRAW_ARB_CLIP_EN
    assign w_clip = (w_g_x >= 8'd160) || (w_g_y >= 7'd120);
`else
    assign w_clip = 1'b0;
`endif

    assign w_timeout = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign w_release = w_g_done || !w_g_req || w_timeout;
    assign w_fwd     = (r_state == S_GRANT) && w_g_wr && !w_clip;

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:    if (w_found)   w_state_next = S_GRANT;
            S_GRANT:   if (w_release) w_state_next = S_RELEASE;
            S_RELEASE: w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_gidx   <= '0;
            r_grant  <= '0;
            r_to_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            unique case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gidx          <= w_pick;
                        r_grant         <= '0;
                        r_grant[w_pick] <= 1'b1;
                        r_to_cnt        <= '0;
                    end
                end
                S_GRANT: begin
                    if (w_release) r_grant <= '0;
                    // Any granted write, clipped or not, counts as activity.
                    if (w_g_wr)                r_to_cnt <= '0;
                    else if (r_to_cnt != '1)   r_to_cnt <= r_to_cnt + 1'b1;
                end
                S_RELEASE: begin
                    if (int'(r_gidx) == NUM_CLIENTS - 1) r_ptr <= '0;
                    else                                 r_ptr <= r_gidx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Pixel fields only move on a forwarded write so they hold while idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_plot  <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
            r_color <= '0;
        end else begin
            r_plot <= w_fwd;
            if (w_fwd) begin
                r_x     <= w_g_x;
                r_y     <= w_g_y;
                r_color <= w_g_color;
            end
        end
    end

    assign grant     = r_grant;
    assign vga_x     = r_x;
    assign vga_y     = r_y;
    assign vga_color = r_color;
    assign vga_plot  = r_plot;
    assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire
